lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Responder side of the core's LSU handshake. The control unit raises lsu_VALID for any load or store and stalls the PC until lsu_READY is seen.
- This block latches the request, runs a data-memory bus transaction with grant/response handshakes, aligns store data and byte enables, and sign/zero-extends load data.
- Returns a one-cycle lsu_READY pulse with the writeback value.
- Sits between the single-cycle datapath (ALU result, rs2, funct3) and the data memory/peripheral bus.

Parameters:
- ADDR_W, 32, data-bus address width; the word address is i_addr[ADDR_W-1:2].
- TIMEOUT_CYC, 255, maximum wait cycles for grant or response before the access aborts; minimum 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- lsu_VALID  in  1  request from control unit; held until lsu_READY
- lsu_READY  out  1  one-cycle completion pulse
- i_st_mem  in  1  1=store, 0=load; sampled with lsu_VALID
- i_funct3  in  3  inst[14:12]: 000 b, 001 h, 010 w, 100 bu, 101 hu
- i_addr  in  32  effective address (ALU result)
- i_st_data  in  32  rs2 value
- o_ld_data  out  32  extended load result; valid while lsu_READY=1
- o_lsu_err  out  1  with lsu_READY: access aborted on timeout or misalignment
- o_mem_req  out  1  bus request
- o_mem_we  out  1  bus write enable
- o_mem_addr  out  ADDR_W  word-aligned address, low two bits 0
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_gnt  in  1  request accepted this cycle
- i_mem_rvalid  in  1  read response valid
- i_mem_rdata  in  32  read data

Behaviour:
- Reset values: state IDLE; every output 0; timeout counter 0.
- The FSM has four states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - lsu_READY=0.
  - If lsu_VALID=1, latch i_st_mem, i_funct3, i_addr[1:0], the word address, and aligned wdata/be; go to REQ.
- REQ:
  - o_mem_req=1; address, we, be and wdata are held stable from the registers.
  - If i_mem_gnt=1: a store goes to DONE; a load goes to WAIT. The counter clears.
- WAIT:
  - o_mem_req=0.
  - If i_mem_rvalid=1: register the extended rdata and go to DONE.
  - An rvalid that arrives in the REQ cycle, together with gnt, is also accepted; the FSM then goes straight to DONE.
- DONE:
  - lsu_READY=1 for exactly one cycle; o_ld_data and o_lsu_err are driven from registers.
  - Next state is always IDLE.
  - lsu_VALID still high in the following IDLE cycle is a new instruction's request and is accepted normally.
- Minimum latency, VALID to READY: store 2 cycles; load 2 cycles with same-cycle rvalid, otherwise 3+.
- Timeout:
  - The counter increments in each REQ or WAIT cycle without progress.
  - At TIMEOUT_CYC the FSM goes to DONE with o_lsu_err=1 and o_ld_data=0.
  - A late rvalid is ignored unless the FSM is in WAIT.
- Store alignment, with a = i_addr[1:0]:
  - sb: be = 1<<a; wdata = {4{st[7:0]}}.
  - sh: be = 0011<<a; wdata = {2{st[15:0]}}.
  - sw: be = 1111; wdata = st.
- Load extraction:
  - Select byte a or half a[1] of rdata.
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Any other funct3 is handled as w.
- lsu_VALID dropping mid-transaction is illegal; the transaction completes regardless.
- Asynchronous reset mid-transaction: immediate return to IDLE, o_mem_req=0, no READY pulse.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned h (a[0]=1) or w (a!=0) goes IDLE -> DONE with no bus request.
  - o_lsu_err=1 and o_ld_data=0.
- Undefined:
  - Misaligned accesses are force-aligned: h uses a[1] only, w ignores a.
  - o_lsu_err is driven only by timeout.

Test Plan:
- sw at 0x100, data 0xDEADBEEF, gnt in the first REQ cycle: o_mem_addr=0x100, be=1111, we=1; READY pulses 2 cycles after VALID, err=0.
- lb at 0x203, rdata 0x80FF_FF12 with rvalid 3 cycles after gnt: o_ld_data=0xFFFFFF80. Repeat as lbu: 0x00000080.
- sh at 0x32, data 0x0000ABCD: be=1100, wdata=0xABCDABCD. Then lhu at 0x32 returning 0xABCD0000: 0x0000ABCD.
- Back-to-back: lw followed immediately by sw with lsu_VALID held high: two distinct bus transactions, two separate READY pulses, no lost request.
- Timeout with TIMEOUT_CYC=4 and gnt never asserted: READY with err=1 after the counter expires; a later gnt is ignored. Assert i_rst mid-WAIT: o_mem_req=0 and IDLE immediately.
- With LSU_MISALIGN_TRAP_EN, lw at 0x101: no o_mem_req, READY with err=1 one cycle after entry. Without the macro: access to word 0x100, err=0.

Source files
------------

// File: rtl/lsu_ctrl.sv
// LSU responder: latches a load/store, runs one data-bus access (req/gnt, rvalid), returns a one-cycle lsu_READY.
// Latency VALID->READY: 2 cycles minimum (store, or load with rvalid alongside gnt), longer while gnt/rvalid are late.
// Stalls on gnt/rvalid up to TIMEOUT_CYC cycles then aborts with o_lsu_err; LSU_MISALIGN_TRAP_EN traps misaligned h/w accesses.
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              lsu_VALID,
    output logic              lsu_READY,
    input  logic              i_st_mem,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_st_data,
    output logic [31:0]       o_ld_data,
    output logic              o_lsu_err,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [3:0]        o_mem_be,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-3:0] waddr_q, waddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       ld_q, ld_d;
    logic              err_q, err_d;

    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        timeout;

    // Halfwords only look at addr[1], so a misaligned h is force-aligned down.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = i_st_data;
        case (i_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << i_addr[1:0];
                st_wdata = {4{i_st_data[7:0]}};
            end
            2'b01: begin
                st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = i_mem_rdata;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (i_funct3[1:0] == 2'b01) ? i_addr[0]
                    : (i_funct3[1:0] != 2'b00) ? (i_addr[1:0] != 2'b00)
                    : 1'b0;
`endif

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (lsu_VALID) begin
                    we_d    = i_st_mem;
                    f3_d    = i_funct3;
                    off_d   = i_addr[1:0];
                    waddr_d = i_addr[ADDR_W-1:2];
                    be_d    = st_be;
                    wdata_d = st_wdata;
                    cnt_d   = '0;
                    ld_d    = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = DONE;
                    end else if (i_mem_rvalid) begin
                        ld_d    = ld_ext;
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    ld_d    = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    cnt_d   = '0;
                    ld_d    = ld_ext;
                    state_d = DONE;
                end else if (timeout) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    ld_d    = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    assign lsu_READY   = (state_q == DONE);
    assign o_ld_data   = ld_q;
    assign o_lsu_err   = err_q;
    assign o_mem_req   = (state_q == REQ);
    assign o_mem_we    = we_q;
    assign o_mem_addr  = {waddr_q, 2'b00};
    assign o_mem_be    = be_q;
    assign o_mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: vector table driven through a bus responder, plus reset/back-to-back/timeout sequences.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_VALID, lsu_READY, i_st_mem, o_lsu_err, o_mem_req, o_mem_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_st_data, o_ld_data, o_mem_addr, o_mem_wdata, i_mem_rdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_gnt, i_mem_rvalid;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
        .i_clk(clk), .i_rst(rst), .lsu_VALID(lsu_VALID), .lsu_READY(lsu_READY),
        .i_st_mem(i_st_mem), .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
        .o_ld_data(o_ld_data), .o_lsu_err(o_lsu_err), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        int          gd, rv, nreq;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic        e_we;
        logic [31:0] e_wdata, e_ld;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata,
                                input int gd, input int rv, input int nreq,
                                input logic [31:0] ea, input logic [3:0] eb, input logic ew,
                                input logic [31:0] ewd, input logic [31:0] eld,
                                input logic eerr, input int elat);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.gd = gd; v.rv = rv; v.nreq = nreq; v.e_addr = ea; v.e_be = eb; v.e_we = ew;
        v.e_wdata = ewd; v.e_ld = eld; v.e_err = eerr; v.e_lat = elat;
        return v;
    endfunction

    // gd: REQ cycles before gnt (999 = never); rv: cycles after gnt until rvalid.
    task automatic run_vec(input vec_t v, input int idx);
        int c, reqc, gcyc, lat;
        logic got, a_we, a_err;
        logic [31:0] a_addr, a_wd, a_ld;
        logic [3:0] a_be;
        a_we = 0; a_err = 0; a_addr = 0; a_wd = 0; a_ld = 0; a_be = 0;
        @(negedge clk);
        lsu_VALID = 1; i_st_mem = v.st; i_funct3 = v.f3; i_addr = v.addr;
        i_st_data = v.sdata; i_mem_rdata = v.rdata; i_mem_gnt = 0; i_mem_rvalid = 0;
        c = 1; reqc = 0; gcyc = -1; got = 0; lat = -1;
        while (!got && c < 60) begin
            @(negedge clk);
            c++;
            i_mem_gnt = 0; i_mem_rvalid = 0;
            if (lsu_READY) begin
                got = 1; lat = c - 1; a_ld = o_ld_data; a_err = o_lsu_err; lsu_VALID = 0;
            end else if (o_mem_req) begin
                if (reqc == 0) begin
                    a_addr = o_mem_addr; a_be = o_mem_be; a_we = o_mem_we; a_wd = o_mem_wdata;
                end
                if (reqc == v.gd) begin
                    i_mem_gnt = 1; gcyc = c;
                end
                reqc++;
            end
            if (!got && !v.st && gcyc >= 0 && c == gcyc + v.rv) i_mem_rvalid = 1;
        end
        lsu_VALID = 0;
        chk("ready_seen", idx, 32'(got), 32'd1);
        chk("latency", idx, lat, v.e_lat);
        chk("ld_data", idx, a_ld, v.e_ld);
        chk("err", idx, 32'(a_err), 32'(v.e_err));
        chk("req_cycles", idx, reqc, v.nreq);
        if (v.nreq > 0) begin
            chk("mem_addr", idx, a_addr, v.e_addr);
            chk("mem_be", idx, 32'(a_be), 32'(v.e_be));
            chk("mem_we", idx, 32'(a_we), 32'(v.e_we));
            chk("mem_wdata", idx, a_wd, v.e_wdata);
        end
    endtask

    initial begin
        int rdy, rq;
        logic [31:0] ra0, ra1, ld0;
        logic rw0, rw1;

        vt[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1, 32'h100, 4'b1111, 1, 32'hDEADBEEF, 32'h0, 0, 2);
        vt[1]  = mk(0, 3'b000, 32'h203, 32'h0, 32'h80FFFF12, 0, 3, 1, 32'h200, 4'b1000, 0, 32'h0, 32'hFFFFFF80, 0, 5);
        vt[2]  = mk(0, 3'b100, 32'h203, 32'h0, 32'h80FFFF12, 0, 3, 1, 32'h200, 4'b1000, 0, 32'h0, 32'h00000080, 0, 5);
        vt[3]  = mk(1, 3'b001, 32'h32, 32'h0000ABCD, 32'h0, 0, 0, 1, 32'h30, 4'b1100, 1, 32'hABCDABCD, 32'h0, 0, 2);
        vt[4]  = mk(0, 3'b101, 32'h32, 32'h0, 32'hABCD0000, 1, 0, 2, 32'h30, 4'b1100, 0, 32'h0, 32'h0000ABCD, 0, 3);
        vt[5]  = mk(0, 3'b001, 32'h30, 32'h0, 32'h12348001, 0, 0, 1, 32'h30, 4'b0011, 0, 32'h0, 32'hFFFF8001, 0, 2);
        vt[6]  = mk(1, 3'b000, 32'h101, 32'h0000005A, 32'h0, 2, 0, 3, 32'h100, 4'b0010, 1, 32'h5A5A5A5A, 32'h0, 0, 4);
        vt[7]  = mk(0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 0, 1, 1, 32'h104, 4'b1111, 0, 32'h0, 32'hCAFEF00D, 0, 3);
`ifdef LSU_MISALIGN_TRAP_EN
        vt[8]  = mk(0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1, 1);
        vt[11] = mk(0, 3'b101, 32'h31, 32'h0, 32'hBEEF7654, 0, 0, 0, 32'h0, 4'b0000, 0, 32'h0, 32'h0, 1, 1);
`else
        vt[8]  = mk(0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0, 1, 32'h100, 4'b1111, 0, 32'h0, 32'h11223344, 0, 2);
        vt[11] = mk(0, 3'b101, 32'h31, 32'h0, 32'hBEEF7654, 0, 0, 1, 32'h30, 4'b0011, 0, 32'h0, 32'h00007654, 0, 2);
`endif
        vt[9]  = mk(0, 3'b010, 32'h40, 32'h0, 32'h55555555, 999, 0, 4, 32'h40, 4'b1111, 0, 32'h0, 32'h0, 1, 5);
        vt[10] = mk(1, 3'b011, 32'h8, 32'h01020304, 32'h0, 0, 0, 1, 32'h8, 4'b1111, 1, 32'h01020304, 32'h0, 0, 2);

        rst = 1; lsu_VALID = 0; i_st_mem = 0; i_funct3 = 0; i_addr = 0; i_st_data = 0;
        i_mem_gnt = 0; i_mem_rvalid = 0; i_mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, 32'(lsu_READY), 0);
        chk("rst_req", 0, 32'(o_mem_req), 0);
        chk("rst_we", 0, 32'(o_mem_we), 0);
        chk("rst_err", 0, 32'(o_lsu_err), 0);
        chk("rst_ld", 0, o_ld_data, 0);
        chk("rst_addr", 0, o_mem_addr, 0);
        chk("rst_be", 0, 32'(o_mem_be), 0);
        chk("rst_wdata", 0, o_mem_wdata, 0);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i], i);
            if (i == 9) begin
                // Late gnt/rvalid after a timeout must not start anything.
                rdy = 0; rq = 0;
                i_mem_gnt = 1; i_mem_rvalid = 1;
                repeat (4) begin
                    @(negedge clk);
                    if (lsu_READY) rdy++;
                    if (o_mem_req) rq++;
                end
                i_mem_gnt = 0; i_mem_rvalid = 0;
                chk("late_gnt_ready", 0, rdy, 0);
                chk("late_gnt_req", 0, rq, 0);
            end
        end

        // Back-to-back: lw then sw with lsu_VALID held across the READY pulse.
        @(negedge clk);
        lsu_VALID = 1; i_st_mem = 0; i_funct3 = 3'b010; i_addr = 32'h10; i_st_data = 0;
        i_mem_rdata = 32'h600DF00D;
        rdy = 0; rq = 0; ra0 = 0; ra1 = 0; rw0 = 1; rw1 = 0; ld0 = 0;
        for (int c = 0; c < 20 && rdy < 2; c++) begin
            @(negedge clk);
            i_mem_gnt = 0; i_mem_rvalid = 0;
            if (lsu_READY) begin
                if (rdy == 0) ld0 = o_ld_data;
                rdy++;
                if (rdy == 1) begin
                    i_st_mem = 1; i_addr = 32'h14; i_st_data = 32'h12345678;
                end else lsu_VALID = 0;
            end else if (o_mem_req) begin
                if (rq == 0) begin ra0 = o_mem_addr; rw0 = o_mem_we; end
                if (rq == 1) begin ra1 = o_mem_addr; rw1 = o_mem_we; end
                rq++;
                i_mem_gnt = 1; i_mem_rvalid = !o_mem_we;
            end
        end
        lsu_VALID = 0;
        chk("b2b_ready_cnt", 0, rdy, 2);
        chk("b2b_req_cnt", 0, rq, 2);
        chk("b2b_addr0", 0, ra0, 32'h10);
        chk("b2b_we0", 0, 32'(rw0), 0);
        chk("b2b_addr1", 0, ra1, 32'h14);
        chk("b2b_we1", 0, 32'(rw1), 1);
        chk("b2b_ld0", 0, ld0, 32'h600DF00D);

        // Reset while in REQ: request drops immediately.
        @(negedge clk);
        lsu_VALID = 1; i_st_mem = 0; i_funct3 = 3'b010; i_addr = 32'h80;
        @(negedge clk);
        chk("pre_rst_req", 0, 32'(o_mem_req), 1);
        rst = 1; #1;
        chk("rst_req_drop", 0, 32'(o_mem_req), 0);
        lsu_VALID = 0;
        @(negedge clk);
        rst = 0;

        // Reset while in WAIT: no READY afterwards, even with a stray rvalid.
        @(negedge clk);
        lsu_VALID = 1;
        @(negedge clk);
        i_mem_gnt = o_mem_req;
        @(negedge clk);
        i_mem_gnt = 0;
        rst = 1; #1;
        chk("rst_wait_req", 0, 32'(o_mem_req), 0);
        chk("rst_wait_ready", 0, 32'(lsu_READY), 0);
        lsu_VALID = 0;
        @(negedge clk);
        rst = 0;
        i_mem_rvalid = 1;
        rdy = 0;
        repeat (4) begin
            @(negedge clk);
            i_mem_rvalid = 0;
            if (lsu_READY) rdy++;
        end
        chk("rst_no_ready", 0, rdy, 0);
        run_vec(vt[0], 12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
